// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of up to
// BURST_LEN writes into a FIFO, stalling on full and ending on withdrawal.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ack,
  input  logic                        full,
  output logic                        push,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [1:0]                  owner,
  output logic                        busy,
  output logic [15:0]                 push_count
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        last, last_nxt, owner_nxt;
  logic [IDX_W-1:0]        grant, cand;
  logic                    grant_vld;
  logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;
  logic [15:0]             push_count_nxt;
  logic                    owner_req;
  logic [DATA_WIDTH-1:0]   words [N_REQ];

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_words
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requester at or after last+1, wrapping around
  always_comb begin
    grant     = last;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IDX_W'((int'(last) + k) % int'(N_REQ));
      if (!grant_vld && req[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  assign owner_req = req[owner];
  assign busy      = (state == BURST);
  assign push      = busy && owner_req && !full;
  assign data_in   = busy ? words[owner] : '0;

  always_comb begin
    req_ack        = '0;
    req_ack[owner] = push;
  end

  // Next-state and register updates
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_nxt       = last;
    burst_cnt_nxt  = burst_cnt;
    push_count_nxt = push_count + {15'd0, push};
    case (state)
      IDLE: begin
        if (grant_vld) begin
          owner_nxt     = grant;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        if (push) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
        if (!owner_req || (push && burst_cnt == LAST_BEAT)) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= LAST_IDX;
      burst_cnt  <= '0;
      push_count <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last       <= last_nxt;
      burst_cnt  <= burst_cnt_nxt;
      push_count <= push_count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a burst-level reference model.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned WBL = 256;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic          full;
  logic          push;
  logic [DW-1:0] data_in;
  logic [1:0]    owner;
  logic          busy;
  logic [15:0]   push_count;

  logic          w_rst;
  logic [NR-1:0] w_req;
  logic [NR*DW-1:0] w_req_data;
  logic [NR-1:0] w_ack;
  logic          w_full;
  logic          w_push;
  logic [DW-1:0] w_data;
  logic [1:0]    w_owner;
  logic          w_busy;
  logic [15:0]   w_count;

  int n_checks;
  int n_errors;

  // reference model: burst-level view (words remaining, not a beat counter)
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_left;
  logic [15:0] m_count;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .full(full), .push(push), .data_in(data_in), .owner(owner), .busy(busy),
    .push_count(push_count)
  );

  // long-burst instance used only to reach the push counter wrap quickly
  fifo_wr_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .BURST_LEN(WBL)) u_wrap (
    .clk(clk), .rst(w_rst), .req(w_req), .req_data(w_req_data), .req_ack(w_ack),
    .full(w_full), .push(w_push), .data_in(w_data), .owner(w_owner), .busy(w_busy),
    .push_count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NR - 1;
    m_left  = 0;
    m_count = 16'd0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit p;
    bit found;
    p = m_busy && req[m_owner] && !full;
    @(posedge clk);
    if (m_busy) begin
      if (p) begin
        m_count = m_count + 16'd1;
        m_left  = m_left - 1;
      end
      if (!req[m_owner] || m_left == 0) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= int'(NR); k++) begin
        if (!found && req[(m_last + k) % NR]) begin
          m_owner = (m_last + k) % NR;
          found   = 1'b1;
        end
      end
      m_busy = 1'b1;
      m_left = BL;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    full = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    full = 1'b0;
    req_data = $urandom;
    #1;
    model_reset();
    n_checks++; if (push !== 1'b0) begin n_errors++; $display("FAIL reset_push got=%b exp=0", push); end
    n_checks++; if (req_ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
    n_checks++; if (data_in !== 8'h00) begin n_errors++; $display("FAIL reset_data got=%h exp=00", data_in); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (push_count !== 16'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", push_count); end
    n_checks++; if (owner !== 2'd0) begin n_errors++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    @(negedge clk);
    rst = 1'b1;
    req = '0;
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    req = 4'b1111;
    req_data = $urandom;
    g = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (m_busy && m_left == BL) begin
        n_checks++;
        if (owner !== 2'(g % 4)) begin
          n_errors++; $display("FAIL rr_grant burst=%0d got=%0d exp=%0d", g, owner, g % 4);
        end
        g++;
      end
      n_checks++;
      if (push !== (m_busy && !full)) begin
        n_errors++; $display("FAIL rr_push cyc=%0d got=%b exp=%b", c, push, m_busy);
      end
      tick();
    end
    n_checks++; if (push_count !== 16'd20) begin n_errors++; $display("FAIL rr_count got=%0d exp=20", push_count); end
    n_checks++; if (g != 5) begin n_errors++; $display("FAIL rr_bursts got=%0d exp=5", g); end
  endtask

  task automatic test_single();
    logic [DW-1:0] w2;
    do_reset();
    w2 = DW'($urandom);
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      req_data = $urandom;
      req_data[2*DW +: DW] = w2;
      #1;
      n_checks++;
      if (push !== ((c % 5) != 0)) begin
        n_errors++; $display("FAIL single_push cyc=%0d got=%b exp=%b", c, push, (c % 5) != 0);
      end
      if ((c % 5) != 0) begin
        n_checks++;
        if (req_ack !== 4'b0100 || data_in !== w2 || owner !== 2'd2) begin
          n_errors++;
          $display("FAIL single_ack cyc=%0d got ack=%b data=%h owner=%0d exp ack=0100 data=%h owner=2",
                   c, req_ack, data_in, owner, w2);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    bit exp_p;
    do_reset();
    req = 4'b0010;
    req_data = $urandom;
    for (int c = 0; c < 11; c++) begin
      full = (c >= 3 && c <= 7);
      exp_p = (c >= 1 && c <= 2) || (c >= 8 && c <= 9);
      #1;
      n_checks++;
      if (push !== exp_p) begin
        n_errors++; $display("FAIL stall_push cyc=%0d got=%b exp=%b", c, push, exp_p);
      end
      if (c >= 1 && c <= 9) begin
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd1) begin
          n_errors++; $display("FAIL stall_owner cyc=%0d got busy=%b owner=%0d exp busy=1 owner=1", c, busy, owner);
        end
      end
      if (c == 10) begin
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL stall_end got busy=%b exp=0", busy); end
      end
      tick();
    end
    full = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_data = $urandom;
    req = 4'b1000;
    tick();
    req = 4'b1001;
    #1;
    n_checks++;
    if (push !== 1'b1 || owner !== 2'd3 || req_ack !== 4'b1000) begin
      n_errors++; $display("FAIL wd_first got push=%b owner=%0d ack=%b exp push=1 owner=3 ack=1000", push, owner, req_ack);
    end
    tick();
    req = 4'b0101;
    #1;
    n_checks++;
    if (push !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL wd_drop got push=%b busy=%b exp push=0 busy=1", push, busy);
    end
    tick();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wd_idle got busy=%b exp=0", busy); end
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b1 || owner !== 2'd0) begin
      n_errors++; $display("FAIL wd_next got busy=%b owner=%0d exp busy=1 owner=0", busy, owner);
    end
    // withdraw while the FIFO is full
    full = 1'b1;
    req = 4'b0100;
    #1;
    n_checks++; if (push !== 1'b0) begin n_errors++; $display("FAIL wd_full_push got=%b exp=0", push); end
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b0 || push_count !== 16'd1) begin
      n_errors++; $display("FAIL wd_full_exit got busy=%b count=%0d exp busy=0 count=1", busy, push_count);
    end
    full = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = $urandom;
    req = 4'b0111;
    for (int c = 0; c < 9; c++) tick();
    #1;
    n_checks++;
    if (push !== 1'b1 || push_count !== 16'd7 || owner !== 2'd1) begin
      n_errors++; $display("FAIL mid_pre got push=%b count=%0d owner=%0d exp push=1 count=7 owner=1", push, push_count, owner);
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (push !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000 || data_in !== 8'h00 || push_count !== 16'd0) begin
      n_errors++;
      $display("FAIL mid_abort got push=%b busy=%b ack=%b data=%h count=%0d exp all zero",
               push, busy, req_ack, data_in, push_count);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0110;
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      n_errors++; $display("FAIL mid_regrant got busy=%b owner=%0d exp busy=1 owner=1", busy, owner);
    end
    tick();
  endtask

  task automatic test_random();
    bit          ep;
    logic [3:0]  ea;
    logic [7:0]  ed;
    do_reset();
    req_data = $urandom;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        if (!req[i]) req_data[i*DW +: DW] = DW'($urandom);
      end
      full = ($urandom_range(3) == 0);
      #1;
      ep = m_busy && req[m_owner] && !full;
      ea = ep ? (4'b0001 << m_owner) : 4'b0000;
      ed = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
      n_checks++; if (push !== ep) begin n_errors++; $display("FAIL rand_push cyc=%0d got=%b exp=%b", c, push, ep); end
      n_checks++; if (req_ack !== ea) begin n_errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", c, req_ack, ea); end
      n_checks++; if (data_in !== ed) begin n_errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, data_in, ed); end
      n_checks++; if (busy !== m_busy) begin n_errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, m_busy); end
      n_checks++; if (push_count !== m_count) begin n_errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, push_count, m_count); end
      if (m_busy) begin
        n_checks++;
        if (owner !== 2'(m_owner)) begin n_errors++; $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", c, owner, m_owner); end
      end
      tick();
    end
    req = '0;
    full = 1'b0;
  endtask

  // Single requester on the long-burst instance: one idle cycle per WBL pushes
  task automatic test_wrap();
    int n;
    int cyc;
    bit exp;
    @(negedge clk);
    w_rst = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 65537) begin
      exp = (cyc % (WBL + 1)) != 0;
      @(posedge clk);
      if (exp) n++;
      @(negedge clk);
      if (exp && n == 65535) begin
        n_checks++;
        if (w_count !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_max got=%h exp=ffff", w_count); end
      end
      cyc++;
    end
    n_checks++;
    if (w_count !== 16'd1) begin n_errors++; $display("FAIL wrap_count got=%0d exp=1", w_count); end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    req        = '0;
    req_data   = '0;
    full       = 1'b0;
    w_rst      = 1'b0;
    w_req      = 4'b0001;
    w_req_data = 32'h0000_00A5;
    w_full     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_full_stall();
    test_withdraw();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
